// File: rtl/ones_frame_accum.sv
// ============================================================================
//  Module   : ones_frame_accum
//  Purpose  : Frame-level accumulator for per-byte ones counts. Totals the
//             4-bit counts of a frame delimited by i_last (or force-closed
//             at MAX_BYTES beats) and presents sum, byte count and peak
//             count as one registered result on a valid/ready handshake.
//  Ports    : i_clk, i_rst        - clock, async active-high reset
//             i_count/i_valid/i_last/o_ready - input beat handshake
//             o_valid/i_ready     - result handshake
//             o_sum/o_bytes/o_peak/o_trunc   - frame result
//             o_err               - sticky illegal-count flag (count > 8)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ones_frame_accum #(
    parameter int MAX_BYTES = 255,
    parameter int SUM_W     = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_count,
    input  logic             i_valid,
    input  logic             i_last,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [SUM_W-1:0] o_sum,
    output logic [7:0]       o_bytes,
    output logic [3:0]       o_peak,
    output logic             o_trunc,
    output logic             o_err
);

    // Byte index (zero-based) of the beat that hits the length cap.
    localparam logic [7:0] c_cap_last = 8'(MAX_BYTES - 1);
    localparam logic [3:0] c_max_cnt  = 4'd8;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [SUM_W-1:0] r_acc_sum;
    logic [7:0]       r_acc_bytes;
    logic [3:0]       r_acc_peak;

    logic [3:0]       w_clamped;
    logic             w_illegal;
    logic             w_accept;
    logic             w_cap;
    logic             w_close;
    logic [SUM_W-1:0] w_sum_next;
    logic [7:0]       w_bytes_next;
    logic [3:0]       w_peak_next;

    always_comb begin
        w_illegal    = (i_count > c_max_cnt);
        w_clamped    = w_illegal ? c_max_cnt : i_count;
        // o_ready is the registered decode of ACCUM, so it doubles as the
        // "in ACCUM" qualifier for the accept strobe.
        w_accept     = i_valid & o_ready;
        w_cap        = (r_acc_bytes == c_cap_last);
        w_close      = i_last | w_cap;
        w_sum_next   = r_acc_sum + SUM_W'(w_clamped);
        w_bytes_next = r_acc_bytes + 8'd1;
        w_peak_next  = (w_clamped > r_acc_peak) ? w_clamped : r_acc_peak;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= INIT;
            r_acc_sum   <= '0;
            r_acc_bytes <= '0;
            r_acc_peak  <= '0;
            o_ready     <= 1'b0;
            o_valid     <= 1'b0;
            o_sum       <= '0;
            o_bytes     <= '0;
            o_peak      <= '0;
            o_trunc     <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_state <= ACCUM;
                    o_ready <= 1'b1;
                end

                ACCUM: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            o_err <= 1'b1;
                        end
                        if (w_close) begin
                            o_sum       <= w_sum_next;
                            o_bytes     <= w_bytes_next;
                            o_peak      <= w_peak_next;
                            // A cap hit that coincides with i_last is a
                            // normal close, not a truncation.
                            o_trunc     <= ~i_last;
                            r_acc_sum   <= '0;
                            r_acc_bytes <= '0;
                            r_acc_peak  <= '0;
                            o_valid     <= 1'b1;
                            o_ready     <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            r_acc_sum   <= w_sum_next;
                            r_acc_bytes <= w_bytes_next;
                            r_acc_peak  <= w_peak_next;
                        end
                    end
                end

                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= ACCUM;
                    end
                end

                default: begin
                    r_state <= INIT;
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
